// File: rtl/pipe_addsub.sv
// Segmented pipelined adder/subtractor: each stage ripples SEG bits and registers the
// carry for the next stage, with a single global advance enable for backpressure.
module pipe_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int SEG = WIDTH / STAGES;

    logic              adv;
    logic [STAGES-1:0] valid_d, valid_q;
    logic [WIDTH-1:0]  a_d     [STAGES];
    logic [WIDTH-1:0]  a_q     [STAGES];
    logic [WIDTH-1:0]  b_d     [STAGES];
    logic [WIDTH-1:0]  b_q     [STAGES];
    logic [WIDTH-1:0]  sum_d   [STAGES];
    logic [WIDTH-1:0]  sum_q   [STAGES];
    logic [STAGES-1:0] carry_d, carry_q;
    logic [STAGES-1:0] cmsb_d, cmsb_q;

    always_comb begin
        logic [WIDTH-1:0] s_prev;
        logic             c_prev;
        logic [SEG-1:0]   sa, sb, ss;
        logic [SEG:0]     cv;
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        adv     = out_ready || !valid_q[STAGES-1];
        valid_d = '0;
        carry_d = '0;
        cmsb_d  = '0;
        for (int k = 0; k < STAGES; k++) begin
            a_d[k]   = '0;
            b_d[k]   = '0;
            sum_d[k] = '0;
        end

        // Stage 0 sees the effective operands; later stages see the skewed registers.
        valid_d[0] = in_valid;
        a_d[0]     = a;
        b_d[0]     = sub ? ~b : b;
        for (int k = 1; k < STAGES; k++) begin
            valid_d[k] = valid_q[k-1];
            a_d[k]     = a_q[k-1];
            b_d[k]     = b_q[k-1];
        end

        for (int k = 0; k < STAGES; k++) begin
            s_prev = (k == 0) ? '0 : sum_q[(k == 0) ? 0 : k-1];
            c_prev = (k == 0) ? (sub ? 1'b1 : cin) : carry_q[(k == 0) ? 0 : k-1];
            sa     = SEG'(a_d[k] >> (k * SEG));
            sb     = SEG'(b_d[k] >> (k * SEG));
            ss     = '0;
            cv     = '0;
            cv[0]  = c_prev;
            for (int i = 0; i < SEG; i++) begin
                ss[i]   = sa[i] ^ sb[i] ^ cv[i];
                cv[i+1] = (sa[i] & sb[i]) | (sa[i] & cv[i]) | (sb[i] & cv[i]);
            end
            sum_d[k]   = s_prev | (WIDTH'(ss) << (k * SEG));
            carry_d[k] = cv[SEG];
            cmsb_d[k]  = cv[SEG-1];
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the data registers are reset as well as the valid bits, so outputs are never X after reset.
        if (rst) begin
            valid_q <= '0;
            carry_q <= '0;
            cmsb_q  <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
            end
        end else if (adv) begin
            // NOTE: non-blocking assignments make every stage sample the previous stage's old value.
            valid_q <= valid_d;
            carry_q <= carry_d;
            cmsb_q  <= cmsb_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                sum_q[k] <= sum_d[k];
            end
        end
    end

    assign in_ready  = adv;
    assign out_valid = valid_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign cout      = carry_q[STAGES-1];
    assign ovf       = carry_q[STAGES-1] ^ cmsb_q[STAGES-1];
    assign zero      = (sum_q[STAGES-1] == '0);

endmodule

// File: tb/tb_pipe_addsub.sv
// Directed bench for pipe_addsub: a 16-bit/4-stage instance and an 8-bit/1-stage instance
// with hand-computed expected results.
module tb_pipe_addsub;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
    logic [15:0] a, b, sum;

    logic        in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, ovf8, zero8;
    logic [7:0]  a8, b8, sum8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_addsub #(.WIDTH(16), .STAGES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    pipe_addsub #(.WIDTH(8), .STAGES(1)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8), .ovf(ovf8), .zero(zero8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Send one beat with out_ready held high, then check latency and result flags.
    task automatic beat16(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                          input logic tcin, input logic tsub, input logic [15:0] esum,
                          input logic ecout, input logic eovf, input logic ezero);
        int lat;
        @(posedge clk); #1;
        a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd4);
        check({tag, "_sum"},  sum,  esum);
        check({tag, "_cout"}, cout, ecout);
        check({tag, "_ovf"},  ovf,  eovf);
        check({tag, "_zero"}, zero, ezero);
    endtask

    initial begin
        int seen;
        int idx;
        int got;
        int cyc;
        logic stall;

        // Reset with in_valid asserted: that beat must never be accepted.
        rst = 1'b1; in_valid = 1'b1; a = 16'h0001; b = 16'h0001; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b1;
        in_valid8 = 1'b1; a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0; in_valid8 = 1'b0;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_sum",       sum,       16'h0000);
        check("rst_cout",      cout,      1'b0);
        check("rst_ovf",       ovf,       1'b0);
        check("rst_zero",      zero,      1'b1);
        check("rst_in_ready",  in_ready,  1'b1);
        check("rst_out_valid8", out_valid8, 1'b0);
        check("rst_zero8",      zero8,      1'b1);
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid || out_valid8) seen++;
        end
        check("rst_in_valid_ignored", 64'(seen), 64'd0);

        beat16("ffff_plus_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        beat16("7fff_plus_1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        beat16("5_minus_7",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        beat16("seg_carry",   16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
        beat16("add_cin",     16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0);
        beat16("sub_equal",   16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        beat16("sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);

        // Back-to-back stream with a three-cycle output stall.
        repeat (2) @(posedge clk);
        idx = 1; got = 0; cyc = 0;
        while (got < 8 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            stall     = (cyc >= 5 && cyc <= 7);
            out_ready = !stall;
            in_valid  = (idx <= 8);
            a = 16'(idx); b = 16'(2 * idx); cin = 1'b0; sub = 1'b0;
            @(negedge clk);
            check($sformatf("stream_in_ready_c%0d", cyc), in_ready, !stall);
            if (in_valid && in_ready) idx++;
            if (out_valid) begin
                if (out_ready) begin
                    got++;
                    check($sformatf("stream_sum_%0d", got), sum, 64'(3 * got));
                end else begin
                    check($sformatf("stall_sum_c%0d", cyc), sum, 64'(3 * (got + 1)));
                end
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("stream_count", 64'(got), 64'd8);
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("stream_no_dup", 64'(seen), 64'd0);

        // Three beats in flight, then reset flushes them.
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            in_valid = 1'b1; a = 16'(16'h0100 * (j + 1)); b = 16'h0011; cin = 1'b0; sub = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("flush_out_valid", out_valid, 1'b0);
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("flush_nothing_emerges", 64'(seen), 64'd0);
        beat16("after_flush", 16'h2000, 16'h0345, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0);

        // Single-stage, 8-bit instance: one-cycle latency.
        @(posedge clk); #1;
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; sub8 = 1'b0; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        check("s1_out_valid", out_valid8, 1'b1);
        check("s1_sum",  sum8,  8'h00);
        check("s1_cout", cout8, 1'b1);
        check("s1_ovf",  ovf8,  1'b1);
        check("s1_zero", zero8, 1'b1);
        @(posedge clk); #1;
        a8 = 8'h05; b8 = 8'h03; cin8 = 1'b1; sub8 = 1'b1; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        check("s1_sub_sum",  sum8,  8'h02);
        check("s1_sub_cout", cout8, 1'b1);
        check("s1_sub_ovf",  ovf8,  1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
